// File: rtl/add_pkg.sv
// add_pkg: shared FSM state type and default geometry for add_multicycle.
package add_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational CHUNK-bit adder with carry in and carry out.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carryIn,
    output logic [CHUNK-1:0] sum,
    output logic             carryOut
);
    assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carryIn};
endmodule

// File: rtl/add_multicycle.sv
// add_multicycle: ripple adder that processes one CHUNK-bit slice per cycle, LSB first.
// Define ADD_OVERFLOW_EN to add a signed-overflow output alongside the result.
module add_multicycle
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy
`ifdef ADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_params
        $fatal(1, "add_multicycle: illegal WIDTH/CHUNK combination");
    end

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, b_r;
    logic             c_r;
    logic [CHUNK-1:0] cs;
    logic             co;

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_r[k*CHUNK +: CHUNK]),
        .b        (b_r[k*CHUNK +: CHUNK]),
        .carryIn  (c_r),
        .sum      (cs),
        .carryOut (co)
    );

    // c_r doubles as the running carry and, once in DONE, the final carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            sum   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inValid) begin
                    a_r   <= a;
                    b_r   <= b;
                    c_r   <= carryIn;
                    k     <= '0;
                    state <= ADD;
                end
                ADD: begin
                    sum[k*CHUNK +: CHUNK] <= cs;
                    c_r <= co;
                    if (k == K_LAST) state <= DONE;
                    else k <= k + 1'b1;
                end
                DONE: if (outReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign inReady  = state == IDLE;
    assign busy     = state != IDLE;
    assign outValid = state == DONE;
    assign carryOut = c_r;

`ifdef ADD_OVERFLOW_EN
    assign overflow = outValid && (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
`endif
endmodule

// File: tb/tb_add_multicycle.sv
// tb_add_multicycle: directed bench with a cycle-level reference model for add_multicycle.
module tb_add_multicycle;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             carryIn = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic             inReady, carryOut, outValid, busy;
    logic [WIDTH-1:0] sum;
`ifdef ADD_OVERFLOW_EN
    logic             overflow;
`endif

    int tests = 0;
    int fails = 0;

    add_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .carryIn  (carryIn),
        .inValid  (inValid),
        .inReady  (inReady),
        .sum      (sum),
        .carryOut (carryOut),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy)
`ifdef ADD_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a transaction is captured on accept, becomes visible
    // NCHUNK edges later and leaves on the first outReady edge after that.
    logic             m_busy, m_valid, m_ovf;
    int               m_cnt;
    logic [WIDTH:0]   m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
            m_ovf   <= 1'b0;
        end else if (!m_busy) begin
            if (inValid) begin
                int s;
                s = int'($signed(a)) + int'($signed(b)) + int'(carryIn);
                m_busy <= 1'b1;
                m_cnt  <= NCHUNK;
                m_res  <= {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carryIn);
                m_ovf  <= (s > 32767) || (s < -32768);
            end
        end else if (!m_valid) begin
            if (m_cnt == 1) m_valid <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (outReady) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_inReady", 32'(inReady), 32'(!m_busy));
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_outValid", 32'(outValid), 32'(m_valid));
            if (m_valid) begin
                check("cyc_sum", 32'(sum), 32'(m_res[WIDTH-1:0]));
                check("cyc_carryOut", 32'(carryOut), 32'(m_res[WIDTH]));
`ifdef ADD_OVERFLOW_EN
                check("cyc_overflow", 32'(overflow), 32'(m_ovf));
`endif
            end
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic oc,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input int hold, input logic early_rdy);
        int lat;
        @(negedge clk);
        a = oa; b = ob; carryIn = oc; inValid = 1'b1; outReady = early_rdy;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        a = 16'h5A5A; b = 16'hC3C3; carryIn = 1'b1;
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(NCHUNK));
        check("lit_sum", 32'(sum), 32'(es));
        check("lit_carryOut", 32'(carryOut), 32'(ec));
`ifdef ADD_OVERFLOW_EN
        check("lit_overflow", 32'(overflow), 32'(eo));
`else
        if (eo === 1'bx) check("lit_overflow_arg", 32'(eo), 32'(0));
`endif
        if (!early_rdy) begin
            inValid = 1'b1; a = 16'hAAAA; b = 16'h1111;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_outValid", 32'(outValid), 32'd1);
                check("hold_sum", 32'(sum), 32'(es));
                check("hold_inReady", 32'(inReady), 32'd0);
            end
            outReady = 1'b1;
        end
        @(posedge clk);
        #1;
        outReady = 1'b0;
        inValid = 1'b0;
        check("release_outValid", 32'(outValid), 32'd0);
        check("release_inReady", 32'(inReady), 32'd1);
    endtask

    initial begin
        #3;
        check("rst_inReady", 32'(inReady), 32'd1);
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carryOut", 32'(carryOut), 32'd0);
        #9 rst_n = 1'b1;

        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'hF0F0, 16'h0001, 1'b0, 16'hF0F1, 1'b0, 1'b0, 0, 1'b1);
        do_op(16'h0005, 16'h0001, 1'b1, 16'h0007, 1'b0, 1'b0, 1, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 2, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 0, 1'b0);

        // abandon an operation mid-flight with k == 2
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; carryIn = 1'b0; inValid = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_outValid", 32'(outValid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_inReady", 32'(inReady), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
